// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM generator: FSM encoding, default timing
// constants and a constant-foldable clog2 helper.
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int DEF_PERIOD_CYC    = 1_000_000;
  localparam int DEF_MIN_PULSE_CYC = 50_000;
  localparam int DEF_STEP_CYC      = 196;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Frame cycle counter for the servo PWM: counts while running, wraps at the
// frame length, and flags the last pulse cycle and the last frame cycle.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int PERIOD_CYC = DEF_PERIOD_CYC,
  parameter int CNT_W      = clog2(DEF_PERIOD_CYC)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run_i,
  input  logic [CNT_W-1:0] pulse_len_i,
  output logic             pulse_end_o,
  output logic             frame_end_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign frame_end_o = (cnt_q == CNT_W'(PERIOD_CYC - 1));
  assign pulse_end_o = (cnt_q == pulse_len_i - CNT_W'(1));

  // Held at zero while idle so the first frame starts at count 0.
  always_comb begin
    cnt_d = '0;
    if (run_i && !frame_end_o) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator with frame-boundary double buffering of the position.
// Optional macro SERVO_PWM_LIMIT_EN clamps written positions to LIMIT_POS.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int PERIOD_CYC    = DEF_PERIOD_CYC,
  parameter int MIN_PULSE_CYC = DEF_MIN_PULSE_CYC,
  parameter int STEP_CYC      = DEF_STEP_CYC,
  parameter int POS_W         = 8,
  parameter int LIMIT_POS     = 200
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [POS_W-1:0] pos_in,
  input  logic             pos_we,
  input  logic             enable,
  output logic             pwm_out,
  output logic             frame_start,
  output logic [POS_W-1:0] active_pos
);

  localparam int CNT_W = clog2(PERIOD_CYC);

  if (MIN_PULSE_CYC + (2**POS_W - 1) * STEP_CYC >= PERIOD_CYC) begin : g_bad_len
    $error("servo_pwm_gen: longest pulse does not fit inside the frame");
  end
  if (MIN_PULSE_CYC < 1) begin : g_bad_min
    $error("servo_pwm_gen: MIN_PULSE_CYC must be at least 1");
  end
  if (LIMIT_POS > 2**POS_W - 1) begin : g_bad_limit
    $error("servo_pwm_gen: LIMIT_POS exceeds the position range");
  end

  state_e           state_q, state_d;
  logic [POS_W-1:0] pending_q, pending_d;
  logic [POS_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pulse_len_q, pulse_len_d;
  logic             pwm_q, fs_q;
  logic             load;
  logic             pulse_end, frame_end;
  logic [POS_W-1:0] pos_lim;

`ifdef SERVO_PWM_LIMIT_EN
  assign pos_lim = (pos_in > POS_W'(LIMIT_POS)) ? POS_W'(LIMIT_POS) : pos_in;
`else
  assign pos_lim = pos_in;
`endif

  servo_frame_timer #(
    .PERIOD_CYC (PERIOD_CYC),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk         (clk),
    .clr         (clr),
    .run_i       (state_q != IDLE),
    .pulse_len_i (pulse_len_q),
    .pulse_end_o (pulse_end),
    .frame_end_o (frame_end)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: if (enable) begin
        state_d = HIGH;
        load    = 1'b1;
      end
      HIGH: if (pulse_end) state_d = LOW;
      LOW: if (frame_end) begin
        if (enable) begin
          state_d = HIGH;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Loads use the pending value from before any coincident write.
  always_comb begin
    pending_d   = pos_we ? pos_lim : pending_q;
    active_d    = load ? pending_q : active_q;
    pulse_len_d = load ? (CNT_W'(MIN_PULSE_CYC) + CNT_W'(pending_q) * CNT_W'(STEP_CYC))
                       : pulse_len_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      active_q    <= '0;
      pulse_len_q <= '0;
      pwm_q       <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      active_q    <= active_d;
      pulse_len_q <= pulse_len_d;
      pwm_q       <= (state_d == HIGH);
      fs_q        <= load;
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_start = fs_q;
  assign active_pos  = active_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen: frame-level reference model checked
// every cycle, plus directed scenarios with hand-computed pulse widths.
module tb_servo_pwm_gen;

  localparam int P    = 1000;
  localparam int MINP = 50;
  localparam int STEP = 1;
  localparam int PW   = 8;
  localparam int LIM  = 200;

  logic          clk = 1'b0;
  logic          clr, pos_we, enable;
  logic [PW-1:0] pos_in;
  logic          pwm_out, frame_start;
  logic [PW-1:0] active_pos;

  always #5 clk = ~clk;

  servo_pwm_gen #(
    .PERIOD_CYC    (P),
    .MIN_PULSE_CYC (MINP),
    .STEP_CYC      (STEP),
    .POS_W         (PW),
    .LIMIT_POS     (LIM)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .pos_in      (pos_in),
    .pos_we      (pos_we),
    .enable      (enable),
    .pwm_out     (pwm_out),
    .frame_start (frame_start),
    .active_pos  (active_pos)
  );

  int tests = 0;
  int fails = 0;

  // Model: whether a frame is running, cycle index within it, and its pulse.
  bit m_run = 0;
  bit m_fs  = 0;
  int m_k = 0, m_len = 0, m_act = 0, m_pend = 0;

  function automatic int lim(input int v);
`ifdef SERVO_PWM_LIMIT_EN
    return (v > LIM) ? LIM : v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic start_frame();
    m_run = 1;
    m_k   = 0;
    m_act = m_pend;
    m_len = MINP + m_pend * STEP;
    m_fs  = 1;
  endtask

  task automatic step();
    @(posedge clk);
    if (clr) begin
      m_run = 0; m_fs = 0; m_k = 0; m_len = 0; m_act = 0; m_pend = 0;
    end else begin
      m_fs = 0;
      if (m_run) begin
        m_k++;
        if (m_k == P) begin
          if (enable) start_frame();
          else begin
            m_run = 0;
            m_k   = 0;
          end
        end
      end else if (enable) begin
        start_frame();
      end
      if (pos_we) m_pend = lim(int'(pos_in));
    end
    #1;
    check("pwm_out", int'(pwm_out), int'(m_run && (m_k < m_len)));
    check("frame_start", int'(frame_start), int'(m_fs));
    check("active_pos", int'(active_pos), m_act);
  endtask

  task automatic wait_fs(input int bound);
    int n;
    n = 0;
    while (!frame_start && n < bound) begin
      step();
      n++;
    end
    check("frame_start_timeout", int'(frame_start), 1);
  endtask

  // Counts high cycles from the current (frame-start) cycle until the next
  // frame start or the cycle limit; optionally writes or disables mid-frame.
  task automatic measure(input int limit, input int wr_at, input int wr_val,
                         input int dis_at, output int hi, output int per,
                         output bit fs_seen);
    hi = int'(pwm_out);
    per = 1;
    fs_seen = 0;
    while (per < limit) begin
      if (per == wr_at) begin
        pos_we = 1'b1;
        pos_in = PW'(wr_val);
      end
      if (per == dis_at) enable = 1'b0;
      step();
      pos_we = 1'b0;
      if (frame_start) begin
        fs_seen = 1;
        break;
      end
      hi += int'(pwm_out);
      per++;
    end
  endtask

  int hi, per;
  bit fs_seen;
  int exp_act, exp_hi;

  initial begin
    clr = 1'b1; pos_we = 1'b0; pos_in = '0; enable = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      pos_in = PW'($urandom);
      pos_we = 1'($urandom);
      enable = 1'($urandom);
      step();
      check("rst_pwm", int'(pwm_out), 0);
      check("rst_fs", int'(frame_start), 0);
      check("rst_active", int'(active_pos), 0);
    end
    clr = 1'b0; pos_we = 1'b0; enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_pwm", int'(pwm_out), 0);
    end

    // Basic pulse at position 20
    pos_in = 8'd20; pos_we = 1'b1;
    step();
    pos_we = 1'b0; enable = 1'b1;
    step();
    check("start_fs", int'(frame_start), 1);
    check("start_pwm", int'(pwm_out), 1);
    check("start_active", int'(active_pos), 20);
    measure(2000, -1, 0, -1, hi, per, fs_seen);
    check("basic_hi", hi, 70);
    check("basic_period", per, 1000);
    check("basic_fs", int'(fs_seen), 1);

    // Mid-frame write of 100 at cycle 30
    measure(2000, 31, 100, -1, hi, per, fs_seen);
    check("mid_hi_cur", hi, 70);
    check("mid_period", per, 1000);
    check("mid_active_next", int'(active_pos), 100);

    // Write of 5 coincident with the last frame cycle
    measure(2000, 1000, 5, -1, hi, per, fs_seen);
    check("mid_hi_next", hi, 150);
    check("edge_active", int'(active_pos), 100);
    measure(2000, -1, 0, -1, hi, per, fs_seen);
    check("edge_hi_old", hi, 150);
    check("edge_active2", int'(active_pos), 5);

    // Disable at cycle 10: pulse completes, frame ends, then idle
    measure(1100, -1, 0, 11, hi, per, fs_seen);
    check("dis_hi", hi, 55);
    check("dis_no_fs", int'(fs_seen), 0);
    check("dis_pwm_idle", int'(pwm_out), 0);

    // Reset during the high phase
    pos_in = PW'($urandom_range(0, 255)); pos_we = 1'b1;
    step();
    pos_we = 1'b0; enable = 1'b1;
    wait_fs(5);
    for (int i = 0; i < 10; i++) step();
    check("pre_clr_pwm", int'(pwm_out), 1);
    clr = 1'b1;
    step();
    check("clr_pwm", int'(pwm_out), 0);
    check("clr_active", int'(active_pos), 0);
    clr = 1'b0; enable = 1'b0;
    step();

    // Full-scale position, clamped only with the limit macro
`ifdef SERVO_PWM_LIMIT_EN
    exp_act = 200; exp_hi = 250;
`else
    exp_act = 255; exp_hi = 305;
`endif
    pos_in = 8'd255; pos_we = 1'b1;
    step();
    pos_we = 1'b0; enable = 1'b1;
    wait_fs(5);
    check("limit_active", int'(active_pos), exp_act);
    measure(2000, -1, 0, -1, hi, per, fs_seen);
    check("limit_hi", hi, exp_hi);

    // Randomised writes, enable toggles and occasional reset
    for (int i = 0; i < 6000; i++) begin
      pos_we = ($urandom_range(0, 99) == 0);
      pos_in = PW'($urandom);
      if ($urandom_range(0, 699) == 0) enable = ~enable;
      clr = ($urandom_range(0, 3999) == 0);
      step();
    end
    clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
